regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised register file with a per-register pending-write scoreboard for the pipelined core.
- Generalises the current register file in four ways: configurable width and depth, write-to-read bypass, an optional hardwired zero register, and per-register outstanding-write counters.
- Decode issues destination reservations. Writeback performs the write and releases the reservation.
- Sits between the decode and writeback stages. Hazard logic consumes rd_busy*.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, 5, address width; must equal log2(DEPTH).
- CNT_W, 2, width of each outstanding-write counter; maximum count is 2^CNT_W-1.
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes and issues.

Ports:
- CLK  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  WIDTH  read port 1 data, combinational.
- rd_data2  out  WIDTH  read port 2 data, combinational.
- rd_busy1  out  1  register at rd_addr1 has an outstanding write.
- rd_busy2  out  1  register at rd_addr2 has an outstanding write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback address.
- wr_data  in  WIDTH  writeback data.
- iss_en  in  1  reserve a destination register.
- iss_addr  in  ADDR_W  destination register to reserve.
- busy_any  out  1  at least one counter is nonzero.
- err_ovf  out  1  sticky flag: issue to a saturated counter.
- err_unf  out  1  sticky flag: write to a register with count 0.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on reset_n. Assertion immediately clears all DEPTH registers, all counters, err_ovf and err_unf; no clock is needed.
- Reset mid-operation: any in-flight issue or write in that cycle is discarded. While reset_n=0, rd_data*=0, rd_busy*=0 and busy_any=0.
- Write: on a rising CLK edge with wr_en=1, rf[wr_addr] <= wr_data. Write latency is one cycle.
- Read: rd_dataN = rf[rd_addrN], combinational.
- Bypass: if wr_en=1 and wr_addr==rd_addrN in the same cycle, rd_dataN = wr_data. Both ports bypass independently.
- Zero register (ZERO_REG=1):
  - Address 0 always reads 0, never bypasses and always reports rd_busy=0.
  - wr_en or iss_en to address 0 has no effect on data, counters or error flags.
- Counter update per register at each rising CLK edge:
  - +1 if iss_en hits that address.
  - -1 if wr_en hits that address.
  - Both hit the same address: counter unchanged.
- Counter saturation: issue alone to a counter at 2^CNT_W-1 leaves it unchanged and sets err_ovf.
- Counter underflow: write alone to a counter at 0 still performs the data write, leaves the counter at 0 and sets err_unf.
- Error flags: err_ovf and err_unf stay set until reset.
- Busy: rd_busyN = (cnt[rd_addrN] - (wr_en && wr_addr==rd_addrN)) != 0, where the subtraction is clamped at 0.
  - A write whose count is 1 releases the register combinationally in the same cycle, consistent with the bypass.
  - An issue in the current cycle is visible from the next cycle only.
- busy_any: OR over all counters of (counter != 0), using registered counter values, with no same-cycle adjustment.
- Outputs are a function of state and current inputs only. There is no combinational path from iss_* to any output.

Test Plan:
- Reset with no clock: write 0xDEADBEEF to r5, drop reset_n for 3ns with no clock edge → rd_data1 (addr 5)=0 immediately; err flags 0.
- Write then read: wr r7=0x12345678 at edge N → rd_data2 (addr 7)=0x12345678 after edge N. In the same cycle, read of r7 with wr_en=1 and wr_data=0xA5A5A5A5 → bypass value 0xA5A5A5A5 before the edge.
- Zero register: wr_en to r0 with 0xFFFFFFFF plus iss_en to r0 → rd_data1=0, rd_busy1=0, busy_any=0, err flags 0. With ZERO_REG=0, r0 reads back 0xFFFFFFFF.
- Scoreboard lifecycle: issue r3 twice (count 2) → rd_busy1=1. First write to r3 → still busy. Second write → rd_busy1=0 combinationally in that cycle, busy_any=0 after the edge.
- Saturation and underflow (CNT_W=2): four issues to r9 → count 3, err_ovf=1 after the 4th edge. Separately, a write to r10 with count 0 → data written, err_unf=1, count 0.
- Simultaneous events: count(r4)=1 with iss_en and wr_en to r4 in the same cycle → count stays 1 and rd_busy=1 next cycle. Assert reset_n=0 while an issue is pending → all counters 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard.
// Ports: CLK/reset_n; 2 comb read ports (data+busy); writeback; issue; busy_any, err_ovf/err_unf.
module regfile_sb #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int CNT_W    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [WIDTH-1:0]  rd_data1,
   output logic [WIDTH-1:0]  rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              busy_any,
   output logic              err_ovf,
   output logic              err_unf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] rf      [DEPTH];
   logic [CNT_W-1:0] cnt     [DEPTH];
   logic [CNT_W-1:0] cnt_nxt [DEPTH];

   logic [DEPTH-1:0] iss_hit;
   logic [DEPTH-1:0] wr_hit;
   logic [DEPTH-1:0] ovf_v;
   logic [DEPTH-1:0] unf_v;
   logic [DEPTH-1:0] nz;

   // Address decode; the hardwired zero register never matches.
   always_comb begin
      iss_hit = '0;
      wr_hit  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!((ZERO_REG != 0) && (i == 0))) begin
            iss_hit[i] = iss_en && (iss_addr == ADDR_W'(i));
            wr_hit[i]  = wr_en && (wr_addr == ADDR_W'(i));
         end
      end
   end

   // Counter next state; simultaneous issue and write cancel out.
   always_comb begin
      ovf_v = '0;
      unf_v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_nxt[i] = cnt[i];
         unique case (1'b1)
            (iss_hit[i] && !wr_hit[i]): begin
               if (cnt[i] == CNT_MAX)
                  ovf_v[i] = 1'b1;
               else
                  cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
            (wr_hit[i] && !iss_hit[i]): begin
               if (cnt[i] == '0)
                  unf_v[i] = 1'b1;
               else
                  cnt_nxt[i] = cnt[i] - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            rf[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wr_hit[i])
               rf[i] <= wr_data;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            cnt[i] <= '0;
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            cnt[i] <= cnt_nxt[i];
         err_ovf <= err_ovf | (|ovf_v);
         err_unf <= err_unf | (|unf_v);
      end
   end

   // Read ports.
   logic             live1;
   logic             live2;
   logic             byp1;
   logic             byp2;
   logic [CNT_W-1:0] c1;
   logic [CNT_W-1:0] c2;

   always_comb begin
      live1 = (ZERO_REG == 0) || (rd_addr1 != '0);
      live2 = (ZERO_REG == 0) || (rd_addr2 != '0);
      byp1  = live1 && wr_en && (wr_addr == rd_addr1);
      byp2  = live2 && wr_en && (wr_addr == rd_addr2);
      c1    = cnt[rd_addr1];
      c2    = cnt[rd_addr2];

      rd_data1 = '0;
      rd_data2 = '0;
      if (reset_n && live1)
         rd_data1 = byp1 ? wr_data : rf[rd_addr1];
      if (reset_n && live2)
         rd_data2 = byp2 ? wr_data : rf[rd_addr2];

      // A same-cycle write releases one pending count.
      rd_busy1 = reset_n && live1 && (c1 != '0) && !((c1 == CNT_ONE) && byp1);
      rd_busy2 = reset_n && live2 && (c2 != '0) && !((c2 == CNT_ONE) && byp2);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         nz[i] = (cnt[i] != '0);
      busy_any = reset_n && (|nz);
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with an expected-value queue.
// Two instances: hardwired zero register on (u0) and off (u1).
module tb_regfile_sb;

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  rd_addr1 = '0, rd_addr2 = '0;
   logic        wr_en = 1'b0, iss_en = 1'b0;
   logic [4:0]  wr_addr = '0, iss_addr = '0;
   logic [31:0] wr_data = '0;

   logic [31:0] rd_data1, rd_data2, z_rd_data1, z_rd_data2;
   logic        rd_busy1, rd_busy2, busy_any, err_ovf, err_unf;
   logic        z_rd_busy1, z_rd_busy2, z_busy_any, z_err_ovf, z_err_unf;

   always #5 CLK = ~CLK;

   regfile_sb #(.ZERO_REG(1)) u0 (
      .CLK(CLK), .reset_n(reset_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .busy_any(busy_any), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   regfile_sb #(.ZERO_REG(0)) u1 (
      .CLK(CLK), .reset_n(reset_n),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
      .rd_busy1(z_rd_busy1), .rd_busy2(z_rd_busy2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .busy_any(z_busy_any), .err_ovf(z_err_ovf), .err_unf(z_err_unf)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sbq[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic expect_v(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sbq.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      nvec++;
      if (sbq.size() == 0) begin
         nerr++;
         $error("FAIL sb_empty: got %h want <queued value>", obs);
      end else begin
         e = sbq.pop_front();
         assert (obs === e.val) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      iss_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12 reset_n = 1'b1;
      step();
      rd_addr1 = 5'd5;
      expect_v("rst_data", 32'h0);
      expect_v("rst_busy_any", 32'h0);
      expect_v("rst_ovf", 32'h0);
      expect_v("rst_unf", 32'h0);
      #1;
      chk(rd_data1);
      chk(busy_any);
      chk(err_ovf);
      chk(err_unf);

      // Zero register, both variants
      rd_addr1 = 5'd0;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      iss_en = 1'b1; iss_addr = 5'd0;
      expect_v("r0_nobyp", 32'h0);
      expect_v("r0_byp_nz", 32'hFFFF_FFFF);
      #1;
      chk(rd_data1);
      chk(z_rd_data1);
      step();
      idle();
      expect_v("r0_data", 32'h0);
      expect_v("r0_busy", 32'h0);
      expect_v("r0_busy_any", 32'h0);
      expect_v("r0_ovf", 32'h0);
      expect_v("r0_unf", 32'h0);
      expect_v("r0_data_nz", 32'hFFFF_FFFF);
      expect_v("r0_unf_nz", 32'h0);
      #1;
      chk(rd_data1);
      chk(rd_busy1);
      chk(busy_any);
      chk(err_ovf);
      chk(err_unf);
      chk(z_rd_data1);
      chk(z_err_unf);

      // Scoreboard lifecycle on r3
      rd_addr1 = 5'd3;
      iss_en = 1'b1; iss_addr = 5'd3;
      expect_v("iss_not_same_cycle", 32'h0);
      #1 chk(rd_busy1);
      step();
      expect_v("iss1_busy", 32'h1);
      #1 chk(rd_busy1);
      step();
      idle();
      expect_v("iss2_busy", 32'h1);
      expect_v("iss2_busy_any", 32'h1);
      #1;
      chk(rd_busy1);
      chk(busy_any);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
      expect_v("wr1_busy", 32'h1);
      #1 chk(rd_busy1);
      step();
      wr_data = 32'h0000_3333;
      expect_v("wr2_release", 32'h0);
      expect_v("wr2_busy_any_reg", 32'h1);
      #1;
      chk(rd_busy1);
      chk(busy_any);
      step();
      idle();
      expect_v("wr2_busy_after", 32'h0);
      expect_v("wr2_busy_any_after", 32'h0);
      expect_v("wr2_unf", 32'h0);
      expect_v("wr2_data", 32'h0000_3333);
      #1;
      chk(rd_busy1);
      chk(busy_any);
      chk(err_unf);
      chk(rd_data1);

      // Simultaneous issue and write on r4
      rd_addr2 = 5'd4;
      iss_en = 1'b1; iss_addr = 5'd4;
      step();
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4;
      step();
      idle();
      expect_v("sim_busy", 32'h1);
      expect_v("sim_ovf", 32'h0);
      expect_v("sim_unf", 32'h0);
      #1;
      chk(rd_busy2);
      chk(err_ovf);
      chk(err_unf);
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
      step();
      idle();
      expect_v("sim_drain_busy_any", 32'h0);
      #1 chk(busy_any);

      // Saturation on r9
      rd_addr1 = 5'd9;
      iss_en = 1'b1; iss_addr = 5'd9;
      step(); step(); step();
      expect_v("sat3_ovf", 32'h0);
      #1 chk(err_ovf);
      step();
      idle();
      expect_v("sat4_ovf", 32'h1);
      expect_v("sat_busy", 32'h1);
      #1;
      chk(err_ovf);
      chk(rd_busy1);
      // Three writes drain r9; a lost saturation would leave it busy
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9;
      step(); step(); step();
      idle();
      expect_v("sat_drain_busy", 32'h0);
      expect_v("sat_drain_unf", 32'h0);
      #1;
      chk(rd_busy1);
      chk(err_unf);

      // Underflow on r10
      rd_addr2 = 5'd10;
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE_F00D;
      step();
      idle();
      expect_v("unf_flag", 32'h1);
      expect_v("unf_data", 32'hCAFE_F00D);
      expect_v("unf_busy", 32'h0);
      expect_v("unf_busy_any", 32'h0);
      #1;
      chk(err_unf);
      chk(rd_data2);
      chk(rd_busy2);
      chk(busy_any);

      // Write then read r7, then bypass on port 2
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
      step();
      idle();
      rd_addr2 = 5'd7;
      expect_v("wr_rd", 32'h1234_5678);
      #1 chk(rd_data2);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
      rd_addr1 = 5'd3;
      expect_v("byp2", 32'hA5A5_A5A5);
      expect_v("byp_other_port", 32'h0000_3333);
      #1;
      chk(rd_data2);
      chk(rd_data1);
      step();
      idle();
      expect_v("byp_stored", 32'hA5A5_A5A5);
      #1 chk(rd_data2);

      // Clockless reset with an issue pending
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
      step();
      idle();
      rd_addr1 = 5'd5;
      iss_en = 1'b1; iss_addr = 5'd2;
      step();
      rd_addr2 = 5'd2;
      expect_v("pre_rst_data", 32'hDEAD_BEEF);
      expect_v("pre_rst_busy_any", 32'h1);
      #1;
      chk(rd_data1);
      chk(busy_any);
      iss_en = 1'b1; iss_addr = 5'd2;
      reset_n = 1'b0;
      expect_v("arst_data", 32'h0);
      expect_v("arst_ovf", 32'h0);
      expect_v("arst_unf", 32'h0);
      expect_v("arst_busy_any", 32'h0);
      expect_v("arst_busy2", 32'h0);
      expect_v("arst_data_nz", 32'h0);
      #1;
      chk(rd_data1);
      chk(err_ovf);
      chk(err_unf);
      chk(busy_any);
      chk(rd_busy2);
      chk(z_rd_data1);
      iss_en = 1'b0;
      #2 reset_n = 1'b1;
      step();
      rd_addr1 = 5'd0;
      expect_v("post_rst_busy2", 32'h0);
      expect_v("post_rst_busy_any", 32'h0);
      expect_v("post_rst_r0_nz", 32'h0);
      #1;
      chk(rd_busy2);
      chk(busy_any);
      chk(z_rd_data1);

      if (sbq.size() != 0) begin
         nvec++;
         nerr++;
         $error("FAIL sb_leftover: got %0d want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
